// File: rtl/mode_controller.sv
// Mode/edit/alarm-ring sequencer for a digital clock: routes one of four BCD
// sources to the display, issues increment pulses while editing and rings the alarm.
module mode_controller #(
    parameter int RING_SECS = 60,
    parameter int IDLE_SECS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_set,
    input  logic        btn_inc,
    input  logic        alarm_match,
    input  logic [15:0] time_bcd,
    input  logic [15:0] alarm_bcd,
    input  logic [15:0] stw_bcd,
    input  logic [15:0] tmr_bcd,
    output logic [15:0] disp_bcd,
    output logic [3:0]  blank_mask,
    output logic [1:0]  mode,
    output logic        hup,
    output logic        mup,
    output logic        almhup,
    output logic        almmup,
    output logic        ring,
    output logic        editing
);

    typedef enum logic [1:0] {VIEW, SET_HR, SET_MIN, RING} state_t;

    localparam int IW = $clog2(IDLE_SECS + 1);
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_SECS - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

    state_t        state, state_nxt;
    logic [1:0]    mode_nxt;
    logic          set_prev, mode_prev, inc_prev, alm_prev;
    logic [IW-1:0] idle_cnt;
    logic [RW-1:0] ring_cnt;
    logic          phase;
    logic          set_press, mode_press, inc_press, any_press;
    logic          sel_set, sel_mode, sel_inc, alm_rise;

    assign set_press  = btn_set  & ~set_prev;
    assign mode_press = btn_mode & ~mode_prev;
    assign inc_press  = btn_inc  & ~inc_prev;
    assign any_press  = set_press | mode_press | inc_press;

    // Only the highest-priority press of a cycle survives.
    assign sel_set  = set_press;
    assign sel_mode = mode_press & ~set_press;
    assign sel_inc  = inc_press & ~set_press & ~mode_press;
    assign alm_rise = alarm_match & ~alm_prev;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        case (state)
            VIEW: begin
                if (alm_rise)                    state_nxt = RING;
                else if (sel_set && !mode[1])    state_nxt = SET_HR;
                else if (sel_mode)               mode_nxt  = mode + 2'd1;
            end
            SET_HR: begin
                if (alm_rise)                    state_nxt = RING;
                else if (sel_set)                state_nxt = SET_MIN;
                else if (!sel_inc && tick_1hz && idle_cnt == IDLE_LAST)
                                                 state_nxt = VIEW;
            end
            SET_MIN: begin
                if (alm_rise)                    state_nxt = RING;
                else if (sel_set)                state_nxt = VIEW;
                else if (!sel_inc && tick_1hz && idle_cnt == IDLE_LAST)
                                                 state_nxt = VIEW;
            end
            RING: begin
                if (any_press || (tick_1hz && ring_cnt == RING_LAST))
                                                 state_nxt = VIEW;
            end
            default:                             state_nxt = VIEW;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= VIEW;
            mode      <= 2'd0;
            set_prev  <= 1'b1;
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
            alm_prev  <= 1'b0;
            idle_cnt  <= '0;
            ring_cnt  <= '0;
            phase     <= 1'b0;
            hup       <= 1'b0;
            mup       <= 1'b0;
            almhup    <= 1'b0;
            almmup    <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode      <= mode_nxt;
            set_prev  <= btn_set;
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            alm_prev  <= alarm_match;

            if (state_nxt != state) phase <= 1'b0;
            else if (tick_1hz)      phase <= ~phase;

            if (state_nxt != SET_HR && state_nxt != SET_MIN)  idle_cnt <= '0;
            else if (state_nxt != state || sel_set || sel_inc) idle_cnt <= '0;
            else if (tick_1hz)                                 idle_cnt <= idle_cnt + 1'b1;

            if (state != RING)  ring_cnt <= '0;
            else if (tick_1hz)  ring_cnt <= ring_cnt + 1'b1;

            // An alarm edge aborts the edit, so it also swallows a same-cycle increment.
            hup    <= (state == SET_HR)  && sel_inc && !alm_rise && (mode == 2'd0);
            almhup <= (state == SET_HR)  && sel_inc && !alm_rise && (mode == 2'd1);
            mup    <= (state == SET_MIN) && sel_inc && !alm_rise && (mode == 2'd0);
            almmup <= (state == SET_MIN) && sel_inc && !alm_rise && (mode == 2'd1);
        end
    end

    assign ring    = (state == RING);
    assign editing = (state == SET_HR) || (state == SET_MIN);

    always_comb begin
        blank_mask = 4'b0000;
        case (state)
            SET_HR:  blank_mask = phase ? 4'b1100 : 4'b0000;
            SET_MIN: blank_mask = phase ? 4'b0011 : 4'b0000;
            RING:    blank_mask = phase ? 4'b1111 : 4'b0000;
            default: blank_mask = 4'b0000;
        endcase
    end

    always_comb begin
        disp_bcd = time_bcd;
        if (state != RING) begin
            case (mode)
                2'd1:    disp_bcd = alarm_bcd;
                2'd2:    disp_bcd = stw_bcd;
                2'd3:    disp_bcd = tmr_bcd;
                default: disp_bcd = time_bcd;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_controller.sv
// Directed self-checking bench for mode_controller: mode cycling, edit pulses,
// idle timeout, alarm ring entry/exit, press priority and reset behaviour.
module tb_mode_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1hz, btn_mode, btn_set, btn_inc, alarm_match;
    logic [15:0] time_bcd, alarm_bcd, stw_bcd, tmr_bcd;
    logic [15:0] disp_bcd;
    logic [3:0]  blank_mask;
    logic [1:0]  mode;
    logic        hup, mup, almhup, almmup, ring, editing;

    int checks = 0;
    int failures = 0;
    int hup_cnt = 0, mup_cnt = 0, almhup_cnt = 0, almmup_cnt = 0, dbl_cnt = 0;
    logic hup_q = 1'b0, mup_q = 1'b0, almhup_q = 1'b0, almmup_q = 1'b0;

    mode_controller dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
        .alarm_match(alarm_match),
        .time_bcd(time_bcd), .alarm_bcd(alarm_bcd), .stw_bcd(stw_bcd), .tmr_bcd(tmr_bcd),
        .disp_bcd(disp_bcd), .blank_mask(blank_mask), .mode(mode),
        .hup(hup), .mup(mup), .almhup(almhup), .almmup(almmup),
        .ring(ring), .editing(editing)
    );

    always #5 clk = ~clk;

    // Counts every increment pulse and any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (hup) hup_cnt++;
        if (mup) mup_cnt++;
        if (almhup) almhup_cnt++;
        if (almmup) almmup_cnt++;
        if ((hup && hup_q) || (mup && mup_q) || (almhup && almhup_q) || (almmup && almmup_q))
            dbl_cnt++;
        hup_q = hup; mup_q = mup; almhup_q = almhup; almmup_q = almmup;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic release_btns();
        btn_mode = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
        step();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; step(); release_btns();
    endtask

    task automatic press_set();
        btn_set = 1'b1; step(); release_btns();
    endtask

    initial begin
        logic [1:0]  exp_mode;
        logic [15:0] exp_disp;
        int          h0;

        reset = 1'b0; tick_1hz = 1'b0; alarm_match = 1'b0;
        btn_mode = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
        time_bcd = 16'h1234; alarm_bcd = 16'h0630; stw_bcd = 16'h0059; tmr_bcd = 16'h0010;
        step(); step();
        check("rst_mode", mode, 2'd0);
        check("rst_ring", ring, 1'b0);
        check("rst_editing", editing, 1'b0);
        check("rst_blank", blank_mask, 4'h0);
        check("rst_pulses", {hup, mup, almhup, almmup}, 4'h0);
        check("rst_disp", disp_bcd, 16'h1234);
        reset = 1'b1;
        step();

        // Mode cycling 1,2,3,0 with matching display source.
        for (int i = 1; i <= 4; i++) begin
            btn_mode = 1'b1; step();
            exp_mode = 2'(i);
            case (exp_mode)
                2'd1: exp_disp = 16'h0630;
                2'd2: exp_disp = 16'h0059;
                2'd3: exp_disp = 16'h0010;
                default: exp_disp = 16'h1234;
            endcase
            check("cyc_mode", mode, exp_mode);
            check("cyc_disp", disp_bcd, exp_disp);
            release_btns();
        end

        // Time edit: 3 hour and 2 minute increments.
        hup_cnt = 0; mup_cnt = 0; almhup_cnt = 0; almmup_cnt = 0; dbl_cnt = 0;
        btn_set = 1'b1; step();
        check("edit_enter", editing, 1'b1);
        check("edit_blank0", blank_mask, 4'h0);
        release_btns();
        for (int i = 0; i < 3; i++) begin
            btn_inc = 1'b1; step();
            check("hup_on", hup, 1'b1);
            release_btns();
            check("hup_off", hup, 1'b0);
        end
        press_set();
        check("in_set_min", editing, 1'b1);
        for (int i = 0; i < 2; i++) begin
            btn_inc = 1'b1; step();
            check("mup_on", mup, 1'b1);
            check("mup_no_hup", hup, 1'b0);
            release_btns();
        end
        press_set();
        check("edit_exit", editing, 1'b0);
        check("hup_total", hup_cnt, 3);
        check("mup_total", mup_cnt, 2);
        check("alm_total", almhup_cnt + almmup_cnt, 0);
        check("single_cycle", dbl_cnt, 0);

        // Alarm edit idle timeout: blink 1100/0000, leave on the 30th tick.
        press_mode();
        check("alm_mode", mode, 2'd1);
        press_set();
        check("alm_edit", editing, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
            if (k < 30) begin
                check("idle_editing", editing, 1'b1);
                check("idle_blank", blank_mask, (k % 2 == 1) ? 4'b1100 : 4'b0000);
            end else begin
                check("idle_exit", editing, 1'b0);
                check("idle_exit_blank", blank_mask, 4'h0);
            end
            step();
        end
        check("idle_no_almhup", almhup_cnt, 0);
        check("idle_mode_kept", mode, 2'd1);

        // Alarm edge during SET_MIN with a same-cycle inc press.
        press_mode(); press_mode(); press_mode();
        check("back_mode0", mode, 2'd0);
        press_set(); press_set();
        h0 = mup_cnt;
        alarm_match = 1'b1; btn_inc = 1'b1; step();
        check("ring_enter", ring, 1'b1);
        check("ring_no_mup", mup, 1'b0);
        check("ring_editing", editing, 1'b0);
        check("ring_disp", disp_bcd, 16'h1234);
        btn_inc = 1'b0; step();
        for (int k = 1; k <= 60; k++) begin
            tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
            if (k < 60) begin
                check("ring_hold", ring, 1'b1);
                check("ring_blank", blank_mask, (k % 2 == 1) ? 4'b1111 : 4'b0000);
            end else begin
                check("ring_timeout", ring, 1'b0);
                check("ring_to_blank", blank_mask, 4'h0);
            end
            step();
        end
        check("ring_mode_kept", mode, 2'd0);
        check("ring_mup_total", mup_cnt, h0);
        step();
        check("no_retrigger", ring, 1'b0);
        alarm_match = 1'b0; step();

        // Button press silences the ring; a held alarm_match does not re-enter.
        alarm_match = 1'b1; step();
        check("ring2_enter", ring, 1'b1);
        h0 = hup_cnt;
        btn_inc = 1'b1; step();
        check("ring2_press", ring, 1'b0);
        check("ring2_no_hup", hup, 1'b0);
        release_btns();
        check("ring2_no_reentry", ring, 1'b0);
        check("ring2_hup_total", hup_cnt, h0);
        alarm_match = 1'b0; step();

        // All three buttons together: only the set press acts.
        btn_set = 1'b1; btn_mode = 1'b1; btn_inc = 1'b1; step();
        check("prio_editing", editing, 1'b1);
        check("prio_mode", mode, 2'd0);
        check("prio_no_hup", hup, 1'b0);
        // Reset mid-edit with a tick and an alarm edge in the same cycle.
        reset = 1'b0; tick_1hz = 1'b1; alarm_match = 1'b1; step();
        tick_1hz = 1'b0; alarm_match = 1'b0;
        check("mid_rst_editing", editing, 1'b0);
        check("mid_rst_ring", ring, 1'b0);
        check("mid_rst_mode", mode, 2'd0);
        check("mid_rst_blank", blank_mask, 4'h0);
        check("mid_rst_pulses", {hup, mup, almhup, almmup}, 4'h0);
        // Buttons held through reset must not register as presses.
        reset = 1'b1; step();
        check("held_no_edit", editing, 1'b0);
        check("held_no_mode", mode, 2'd0);
        release_btns();
        check("final_pulses", {hup, mup, almhup, almmup}, 4'h0);
        check("final_single_cycle", dbl_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 Parameter RING_SECS, default 60, number of 1 Hz ticks alarm rings before self-clearing.
REQ-002 Parameter IDLE_SECS, default 30, number of 1 Hz ticks without a press before an edit session is abandoned.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 tick_1hz  in  1  single-cycle pulse, once per second, synchronous to clk.
REQ-006 btn_mode, btn_set, btn_inc  in  1 each  debounced button levels, synchronous to clk.
REQ-007 alarm_match  in  1  level, high while current time equals armed alarm time.
REQ-008 time_bcd, alarm_bcd, stw_bcd, tmr_bcd  in  16 each  four BCD digits {d3,d2,d1,d0} from each display source.
REQ-009 disp_bcd  out  16  digits routed to the 7-segment driver.
REQ-010 blank_mask  out  4  bit i high blanks digit i.
REQ-011 mode  out  2  0 TIME, 1 ALARM, 2 STOPWATCH, 3 TIMER.
REQ-012 hup, mup, almhup, almmup  out  1 each  single-cycle increment pulses to time and alarm counters.
REQ-013 ring  out  1  high while alarm is ringing.
REQ-014 editing  out  1  high in SET_HR or SET_MIN.

Function
REQ-015 Each button SHALL be rising-edge detected internally; a press = level 1 this cycle, 0 previous cycle; previous-level registers reset to 1 so a button held through reset yields no press.
REQ-016 At most one press acted on per cycle, priority btn_set > btn_mode > btn_inc; lower-priority simultaneous presses discarded.
REQ-017 FSM states: VIEW, SET_HR, SET_MIN, RING.
REQ-018 VIEW: mode press -> mode = (mode+1) mod 4 (3 wraps to 0); set press with mode 0 or 1 -> SET_HR; set press in mode 2/3 ignored; inc press ignored.
REQ-019 SET_HR: inc press -> one-cycle pulse on hup (mode 0) or almhup (mode 1) in the cycle after the press; set press -> SET_MIN; mode press ignored.
REQ-020 SET_MIN: inc press -> one-cycle pulse on mup (mode 0) or almmup (mode 1) in the cycle after the press; set press -> VIEW.
REQ-021 Idle counter cleared on SET_HR entry and on every acted-on press; incremented on tick_1hz in SET states; reaching IDLE_SECS -> VIEW, no pulse; press and tick in same cycle: press wins, counter cleared.
REQ-022 Rising edge of alarm_match in any non-RING state -> RING next cycle; edit aborted, no increment pulse issued that cycle, mode preserved.
REQ-023 RING: ring=1; any button press (consumed, no other effect) or RING_SECS ticks -> VIEW; alarm_match staying high does not re-trigger.
REQ-024 disp_bcd = source selected by mode (0 time, 1 alarm, 2 stw, 3 tmr) combinationally from registered state; in RING disp_bcd = time_bcd.
REQ-025 Blink phase register toggles on tick_1hz, cleared to 0 on every state change.
REQ-026 blank_mask: VIEW 4'b0000; SET_HR 4'b1100 when phase=1 else 0; SET_MIN 4'b0011 when phase=1 else 0; RING 4'b1111 when phase=1 else 0.
REQ-027 Increment pulses never exceed one cycle and never assert outside SET_HR/SET_MIN.

Reset
REQ-028 reset=0 at a clock edge SHALL force state VIEW, mode 0, ring 0, editing 0, all pulses 0, blank_mask 0, idle/ring counters 0, phase 0, alarm_match edge register 0, regardless of state mid-operation.
REQ-029 Reset has priority over all presses, ticks and alarm_match in the same cycle.

Verification
REQ-030 Four mode presses from reset -> mode 1,2,3,0; disp_bcd follows alarm_bcd, stw_bcd, tmr_bcd, time_bcd.
REQ-031 Mode 0: set, inc x3, set, inc x2, set -> exactly 3 hup and 2 mup single-cycle pulses, state back to VIEW, editing 0.
REQ-032 Mode 1 in SET_HR, 30 ticks without press -> VIEW on 30th tick, no almhup; blank_mask toggles 1100/0000 per tick meanwhile.
REQ-033 alarm_match rises during SET_MIN with inc pressed same cycle -> RING, no mup, ring 1; 60 ticks later ring 0, VIEW, mode 0.
REQ-034 RING, btn_inc press -> ring 0 next cycle, no hup; alarm_match still high -> no re-entry.
REQ-035 set+mode+inc pressed same cycle in VIEW mode 0 -> SET_HR only, mode unchanged; reset=0 asserted there -> all outputs reset values next cycle.
